// File: rtl/ex_stage_pipe_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage.
// master drives the instruction slot, slave is the stage.
interface ex_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            stall_in;
  logic            flush;
  logic            RegDst;
  logic            ALUsrc;
  logic            MemtoReg;
  logic            MemRead;
  logic            MemWrite;
  logic            Branch;
  logic            RegWrite;
  logic [1:0]      ALUop;
  logic [5:0]      Fuc;
  logic [XLEN-1:0] PCplus4;
  logic [XLEN-1:0] Adat;
  logic [XLEN-1:0] Bdat;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [4:0]      rt;
  logic [1:0]      fwdA;
  logic [1:0]      fwdB;
  logic [XLEN-1:0] fwd_mem;
  logic [XLEN-1:0] fwd_wb;
  logic            ex_busy;
  logic            o_valid;
  logic            oMemtoReg;
  logic            oMemWrite;
  logic            oMemRead;
  logic            oBranch;
  logic            oRegWrite;
  logic [XLEN-1:0] opcplusimediate;
  logic [XLEN-1:0] ooALU;
  logic [XLEN-1:0] oBdat;
  logic            ozero;
  logic [4:0]      oregW;

  modport master (
    output i_valid, stall_in, flush,
    output RegDst, ALUsrc, MemtoReg, MemRead,
    output MemWrite, Branch, RegWrite,
    output ALUop, Fuc, PCplus4, Adat, Bdat, imm,
    output rd, rt, fwdA, fwdB, fwd_mem, fwd_wb,
    input  ex_busy, o_valid,
    input  oMemtoReg, oMemWrite, oMemRead,
    input  oBranch, oRegWrite,
    input  opcplusimediate, ooALU, oBdat,
    input  ozero, oregW
  );

  modport slave (
    input  i_valid, stall_in, flush,
    input  RegDst, ALUsrc, MemtoReg, MemRead,
    input  MemWrite, Branch, RegWrite,
    input  ALUop, Fuc, PCplus4, Adat, Bdat, imm,
    input  rd, rt, fwdA, fwdB, fwd_mem, fwd_wb,
    output ex_busy, o_valid,
    output oMemtoReg, oMemWrite, oMemRead,
    output oBranch, oRegWrite,
    output opcplusimediate, ooALU, oBdat,
    output ozero, oregW
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// Execute stage: forwarding, ALU, branch target,
// iterative multiplier and the EX/MEM register.
module ex_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int IMM_SHIFT = 2,
  parameter int MUL_EN    = 1
) (
  input logic           clkd,
  input logic           rst,
  ex_stage_pipe_if.slave bus
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  typedef struct packed {
    logic mtr;
    logic mw;
    logic mr;
    logic br;
    logic rw;
  } ctl_t;

  state_t state, state_nx;

  logic [XLEN-1:0] a, bf, b, tgt, res;
  logic [4:0]      regw;
  ctl_t            ctl;
  logic            is_mul, start;

  logic [XLEN-1:0] m_a, m_b, acc;
  logic [XLEN-1:0] l_tgt, l_bf;
  logic [4:0]      l_regw;
  ctl_t            l_ctl;
  logic [CW-1:0]   cnt;

  logic            ex_vld, ex_zero;
  ctl_t            ex_ctl;
  logic [XLEN-1:0] ex_alu, ex_tgt, ex_bdat;
  logic [4:0]      ex_regw;

  // Forwarding muxes; select 11 falls back to the register file.
  always_comb begin
    a  = bus.Adat;
    bf = bus.Bdat;
    unique case (bus.fwdA)
      2'b01:   a = bus.fwd_mem;
      2'b10:   a = bus.fwd_wb;
      default: a = bus.Adat;
    endcase
    unique case (bus.fwdB)
      2'b01:   bf = bus.fwd_mem;
      2'b10:   bf = bus.fwd_wb;
      default: bf = bus.Bdat;
    endcase
  end

  assign b    = bus.ALUsrc ? bus.imm : bf;
  assign tgt  = bus.PCplus4 + (bus.imm << IMM_SHIFT);
  assign regw = bus.RegDst ? bus.rd : bus.rt;
  assign ctl  = {bus.MemtoReg, bus.MemWrite, bus.MemRead,
                 bus.Branch, bus.RegWrite};

  assign is_mul = (MUL_EN != 0) && (bus.ALUop == 2'b10)
                  && (bus.Fuc == 6'b011000);

  // Single-cycle ALU; unknown functs (and multiply) give 0.
  always_comb begin
    res = '0;
    unique case (bus.ALUop)
      2'b01: res = a - b;
      2'b10: begin
        unique case (bus.Fuc)
          6'b100000: res = a + b;
          6'b100010: res = a - b;
          6'b100100: res = a & b;
          6'b100101: res = a | b;
          6'b100111: res = ~(a | b);
          6'b101010: res = {{(XLEN-1){1'b0}},
                            ($signed(a) < $signed(b))};
          default:   res = '0;
        endcase
      end
      default: res = a + b;
    endcase
  end

  // Multiplier sequencing; a flush aborts any multiply in flight.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_valid && is_mul && !bus.flush) begin
          start    = 1'b1;
          state_nx = MUL;
        end
      end
      MUL: begin
        if (bus.flush)
          state_nx = IDLE;
        else if (cnt == LAST)
          state_nx = DONE;
      end
      DONE: begin
        if (bus.flush || !bus.stall_in)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.ex_busy = start
    | ((state == MUL) & ~bus.flush)
    | ((state == DONE) & bus.stall_in & ~bus.flush);

  // FSM state register.
  always_ff @(posedge clkd) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Shift-add multiplier; the extra MUL cycle at cnt==LAST is idle.
  always_ff @(posedge clkd) begin
    if (rst) begin
      m_a    <= '0;
      m_b    <= '0;
      acc    <= '0;
      cnt    <= '0;
      l_tgt  <= '0;
      l_bf   <= '0;
      l_regw <= '0;
      l_ctl  <= '0;
    end else if (start) begin
      m_a    <= a;
      m_b    <= b;
      acc    <= '0;
      cnt    <= '0;
      l_tgt  <= tgt;
      l_bf   <= bf;
      l_regw <= regw;
      l_ctl  <= ctl;
    end else if (state == MUL && cnt != LAST) begin
      if (m_b[0])
        acc <= acc + m_a;
      m_a <= m_a << 1;
      m_b <= m_b >> 1;
      cnt <= cnt + CW'(1);
    end
  end

  // EX/MEM register: rst > flush > stall > load.
  always_ff @(posedge clkd) begin
    if (rst) begin
      ex_vld  <= 1'b0;
      ex_ctl  <= '0;
      ex_alu  <= '0;
      ex_zero <= 1'b0;
      ex_tgt  <= '0;
      ex_bdat <= '0;
      ex_regw <= '0;
    end else if (bus.flush || !bus.stall_in) begin
      ex_vld  <= 1'b0;
      ex_ctl  <= '0;
      ex_alu  <= res;
      ex_zero <= (res == '0);
      ex_tgt  <= tgt;
      ex_bdat <= bf;
      ex_regw <= regw;
      if (!bus.flush) begin
        if (state == DONE) begin
          ex_vld  <= 1'b1;
          ex_ctl  <= l_ctl;
          ex_alu  <= acc;
          ex_zero <= (acc == '0);
          ex_tgt  <= l_tgt;
          ex_bdat <= l_bf;
          ex_regw <= l_regw;
        end else if (!start && state != MUL) begin
          ex_vld <= bus.i_valid;
          ex_ctl <= bus.i_valid ? ctl : '0;
        end
      end
    end
  end

  assign bus.o_valid         = ex_vld;
  assign bus.oMemtoReg       = ex_ctl.mtr;
  assign bus.oMemWrite       = ex_ctl.mw;
  assign bus.oMemRead        = ex_ctl.mr;
  assign bus.oBranch         = ex_ctl.br;
  assign bus.oRegWrite       = ex_ctl.rw;
  assign bus.ooALU           = ex_alu;
  assign bus.ozero           = ex_zero;
  assign bus.opcplusimediate = ex_tgt;
  assign bus.oBdat           = ex_bdat;
  assign bus.oregW           = ex_regw;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe at XLEN=32 and XLEN=8.
// Driver pushes expectations; monitors pop on every loaded result.
module tb_ex_stage_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_pipe_if #(.XLEN(32)) bus32();
  ex_stage_pipe_if #(.XLEN(8))  bus8();

  ex_stage_pipe #(.XLEN(32), .IMM_SHIFT(2), .MUL_EN(1)) u32 (
    .clkd(clk), .rst(rst), .bus(bus32)
  );
  ex_stage_pipe #(.XLEN(8), .IMM_SHIFT(2), .MUL_EN(1)) u8 (
    .clkd(clk), .rst(rst), .bus(bus8)
  );

  typedef struct {
    bit        vld, RegDst, ALUsrc, MemtoReg, MemRead;
    bit        MemWrite, Branch, RegWrite;
    bit [1:0]  op, fa, fb;
    bit [5:0]  fuc;
    bit [31:0] pc, a, b, imm, fm, fw;
    bit [4:0]  rd, rt;
  } ins_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] tgt;
    logic [31:0] bdat;
    logic        zero;
    logic [4:0]  regw;
    logic [4:0]  ctl;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic exp_t mk(logic [31:0] alu, logic [31:0] tgt,
                              logic [31:0] bdat, logic z,
                              logic [4:0] rw, logic [4:0] c);
    exp_t e;
    e.alu = alu; e.tgt = tgt; e.bdat = bdat;
    e.zero = z; e.regw = rw; e.ctl = c;
    return e;
  endfunction

  // Reference: arithmetic on 64-bit values, masked to xl bits.
  function automatic exp_t model(ins_t s, int xl);
    exp_t e;
    logic [63:0] m, a, bf, b, r, t;
    bit lt;
    m  = (64'd1 << xl) - 64'd1;
    a  = (s.fa == 2'd1 ? s.fm : s.fa == 2'd2 ? s.fw : s.a) & m;
    bf = (s.fb == 2'd1 ? s.fm : s.fb == 2'd2 ? s.fw : s.b) & m;
    b  = s.ALUsrc ? ({32'd0, s.imm} & m) : bf;
    lt = (a[xl-1] != b[xl-1]) ? a[xl-1] : (a < b);
    case (s.op)
      2'd1: r = a - b;
      2'd2: begin
        case (s.fuc)
          6'b100000: r = a + b;
          6'b100010: r = a - b;
          6'b100100: r = a & b;
          6'b100101: r = a | b;
          6'b100111: r = ~(a | b);
          6'b101010: r = {63'd0, lt};
          6'b011000: r = a * b;
          default:   r = 64'd0;
        endcase
      end
      default: r = a + b;
    endcase
    r = r & m;
    t = ({32'd0, s.pc} + ({32'd0, s.imm} << 2)) & m;
    e.alu  = r[31:0];
    e.tgt  = t[31:0];
    e.bdat = bf[31:0];
    e.zero = (r == 64'd0);
    e.regw = s.RegDst ? s.rd : s.rt;
    e.ctl  = {s.MemtoReg, s.MemWrite, s.MemRead, s.Branch, s.RegWrite};
    return e;
  endfunction

  function automatic ins_t blank();
    ins_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic drive(ins_t s, bit sel);
    if (!sel) begin
      bus32.i_valid = s.vld;    bus32.RegDst = s.RegDst;
      bus32.ALUsrc = s.ALUsrc;  bus32.MemtoReg = s.MemtoReg;
      bus32.MemRead = s.MemRead; bus32.MemWrite = s.MemWrite;
      bus32.Branch = s.Branch;  bus32.RegWrite = s.RegWrite;
      bus32.ALUop = s.op;       bus32.Fuc = s.fuc;
      bus32.PCplus4 = s.pc;     bus32.Adat = s.a;
      bus32.Bdat = s.b;         bus32.imm = s.imm;
      bus32.rd = s.rd;          bus32.rt = s.rt;
      bus32.fwdA = s.fa;        bus32.fwdB = s.fb;
      bus32.fwd_mem = s.fm;     bus32.fwd_wb = s.fw;
    end else begin
      bus8.i_valid = s.vld;     bus8.RegDst = s.RegDst;
      bus8.ALUsrc = s.ALUsrc;   bus8.MemtoReg = s.MemtoReg;
      bus8.MemRead = s.MemRead; bus8.MemWrite = s.MemWrite;
      bus8.Branch = s.Branch;   bus8.RegWrite = s.RegWrite;
      bus8.ALUop = s.op;        bus8.Fuc = s.fuc;
      bus8.PCplus4 = s.pc[7:0]; bus8.Adat = s.a[7:0];
      bus8.Bdat = s.b[7:0];     bus8.imm = s.imm[7:0];
      bus8.rd = s.rd;           bus8.rt = s.rt;
      bus8.fwdA = s.fa;         bus8.fwdB = s.fb;
      bus8.fwd_mem = s.fm[7:0]; bus8.fwd_wb = s.fw[7:0];
    end
  endtask

  task automatic setsf(bit sel, bit st, bit fl);
    if (!sel) begin
      bus32.stall_in = st; bus32.flush = fl;
    end else begin
      bus8.stall_in = st;  bus8.flush = fl;
    end
  endtask

  task automatic novalid(bit sel);
    if (!sel) bus32.i_valid = 1'b0;
    else      bus8.i_valid = 1'b0;
    setsf(sel, 1'b0, 1'b0);
  endtask

  function automatic logic busy(bit sel);
    return sel ? bus8.ex_busy : bus32.ex_busy;
  endfunction

  function automatic logic ov(bit sel);
    return sel ? bus8.o_valid : bus32.o_valid;
  endfunction

  function automatic exp_t out32();
    return mk(bus32.ooALU, bus32.opcplusimediate, bus32.oBdat,
              bus32.ozero, bus32.oregW,
              {bus32.oMemtoReg, bus32.oMemWrite, bus32.oMemRead,
               bus32.oBranch, bus32.oRegWrite});
  endfunction

  function automatic exp_t out8();
    return mk({24'd0, bus8.ooALU}, {24'd0, bus8.opcplusimediate},
              {24'd0, bus8.oBdat}, bus8.ozero, bus8.oregW,
              {bus8.oMemtoReg, bus8.oMemWrite, bus8.oMemRead,
               bus8.oBranch, bus8.oRegWrite});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the instruction until an edge with neither busy nor stall.
  task automatic issue(input ins_t s, input bit sel, input bit rstall,
                       output int nb, output int nv);
    bit go;
    bit st;
    int n;
    nb = 0; nv = 0; n = 0; go = 1'b0;
    drive(s, sel);
    while (!go && n < 300) begin
      st = rstall && ($urandom_range(0, 3) == 0);
      setsf(sel, st, 1'b0);
      @(negedge clk);
      if (busy(sel)) begin
        nb++;
        if (ov(sel)) nv++;
      end
      go = !busy(sel) && !st;
      step();
      n++;
    end
    novalid(sel);
    n_chk++;
    if (!go) begin
      n_fail++;
      $display("FAIL issue_timeout: got busy after %0d cycles required done", n);
    end
  endtask

  // Monitors: compare only when the EX/MEM register actually loaded.
  always begin : mon32
    bit adv;
    exp_t e;
    @(posedge clk);
    adv = (!bus32.stall_in || bus32.flush) && !rst;
    @(negedge clk);
    if (adv && bus32.o_valid) begin
      n_chk++;
      if (q32.size() == 0) begin
        n_fail++;
        $display("FAIL sb32_extra: got %0h required no result", out32());
      end else begin
        e = q32.pop_front();
        if (out32() !== e) begin
          n_fail++;
          $display("FAIL sb32: got %0h required %0h", out32(), e);
        end
      end
    end
  end

  always begin : mon8
    bit adv;
    exp_t e;
    @(posedge clk);
    adv = (!bus8.stall_in || bus8.flush) && !rst;
    @(negedge clk);
    if (adv && bus8.o_valid) begin
      n_chk++;
      if (q8.size() == 0) begin
        n_fail++;
        $display("FAIL sb8_extra: got %0h required no result", out8());
      end else begin
        e = q8.pop_front();
        if (out8() !== e) begin
          n_fail++;
          $display("FAIL sb8: got %0h required %0h", out8(), e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  function automatic ins_t rnd();
    ins_t s;
    bit [5:0] tbl [8];
    tbl[0] = 6'b100000; tbl[1] = 6'b100010; tbl[2] = 6'b100100;
    tbl[3] = 6'b100101; tbl[4] = 6'b100111; tbl[5] = 6'b101010;
    tbl[6] = 6'b011000; tbl[7] = 6'($urandom);
    s = blank();
    s.vld = 1'b1;
    {s.RegDst, s.ALUsrc, s.MemtoReg, s.MemRead} = 4'($urandom);
    {s.MemWrite, s.Branch, s.RegWrite} = 3'($urandom);
    s.op = 2'($urandom_range(0, 3));
    s.fuc = tbl[$urandom_range(0, 7)];
    s.fa = 2'($urandom); s.fb = 2'($urandom);
    s.pc = $urandom; s.a = $urandom; s.b = $urandom;
    s.imm = $urandom; s.fm = $urandom; s.fw = $urandom;
    s.rd = 5'($urandom); s.rt = 5'($urandom);
    if ($urandom_range(0, 4) == 0) begin
      s.a = s.b; s.fa = 2'd0; s.fb = 2'd0; s.ALUsrc = 1'b0;
    end
    return s;
  endfunction

  initial begin
    ins_t s, add;
    int nb, nv, cnt;
    rst = 1'b1;
    drive(blank(), 1'b0); drive(blank(), 1'b1);
    setsf(1'b0, 1'b0, 1'b0); setsf(1'b1, 1'b0, 1'b0);
    step(); step();
    @(negedge clk);
    chk("rst32", {out32(), bus32.o_valid, bus32.ex_busy}, 128'd0);
    chk("rst8", {out8(), bus8.o_valid, bus8.ex_busy}, 128'd0);
    step();
    rst = 1'b0;
    step();

    add = blank();
    add.vld = 1'b1; add.a = 5; add.b = 7; add.op = 2'b10;
    add.fuc = 6'b100000; add.RegDst = 1'b1; add.rd = 9;
    add.RegWrite = 1'b1;
    q32.push_back(mk(12, 0, 7, 1'b0, 9, 5'b00001));
    issue(add, 1'b0, 1'b0, nb, nv);
    chk("add_busy", nb, 0);

    s = blank();
    s.vld = 1'b1; s.fa = 2'b01; s.fm = 100; s.ALUsrc = 1'b1;
    s.imm = 32'hFFFF_FFFC; s.fb = 2'b10; s.fw = 32'hAB; s.rt = 4;
    q32.push_back(mk(96, 32'hFFFF_FFF0, 32'hAB, 1'b0, 4, 5'b0));
    issue(s, 1'b0, 1'b0, nb, nv);

    s = blank();
    s.vld = 1'b1; s.pc = 32'h100; s.imm = 3; s.op = 2'b01;
    s.a = 8; s.b = 8; s.Branch = 1'b1;
    q32.push_back(mk(0, 32'h10C, 8, 1'b1, 0, 5'b00010));
    issue(s, 1'b0, 1'b0, nb, nv);
    drive(s, 1'b0);
    setsf(1'b0, 1'b0, 1'b1);
    step();
    novalid(1'b0);
    @(negedge clk);
    chk("flush_br", {bus32.o_valid, bus32.oBranch,
                     bus32.opcplusimediate}, {2'b00, 32'h10C});
    step();

    q32.push_back(mk(12, 0, 7, 1'b0, 9, 5'b00001));
    issue(add, 1'b0, 1'b0, nb, nv);
    setsf(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    setsf(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_stall", {out32(), bus32.o_valid, bus32.ex_busy}, 128'd0);
    step();
    q32.push_back(mk(12, 0, 7, 1'b0, 9, 5'b00001));
    issue(add, 1'b0, 1'b0, nb, nv);

    s = add; s.a = 13; s.b = 11; s.fuc = 6'b011000; s.rd = 3;
    step(); step();
    q32.push_back(mk(143, 0, 11, 1'b0, 3, 5'b00001));
    issue(s, 1'b0, 1'b0, nb, nv);
    chk("mul32_busy", nb, 34);
    chk("mul32_bubble", nv, 0);

    step(); step();
    q8.push_back(mk(143, 0, 11, 1'b0, 3, 5'b00001));
    issue(s, 1'b1, 1'b0, nb, nv);
    chk("mul8_busy", nb, 10);
    chk("mul8_bubble", nv, 0);
    @(negedge clk);
    chk("mul8_res", {bus8.o_valid, bus8.ooALU}, {1'b1, 8'd143});
    step();

    s.a = 16; s.b = 16;
    q8.push_back(mk(0, 0, 16, 1'b1, 3, 5'b00001));
    issue(s, 1'b1, 1'b0, nb, nv);

    s.a = 13; s.b = 11;
    step(); step();
    q8.push_back(mk(143, 0, 11, 1'b0, 3, 5'b00001));
    drive(s, 1'b1);
    repeat (10) step();
    setsf(1'b1, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("done_stall", {bus8.ex_busy, bus8.o_valid}, 2'b10);
      step();
    end
    setsf(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_release", bus8.ex_busy, 0);
    step();
    novalid(1'b1);
    @(negedge clk);
    chk("done_issue", {bus8.o_valid, bus8.ooALU}, {1'b1, 8'd143});
    step();

    drive(s, 1'b1);
    repeat (4) step();
    setsf(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_mul_busy", bus8.ex_busy, 0);
    step();
    novalid(1'b1);
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.o_valid) cnt++;
      step();
    end
    chk("flush_mul_nores", cnt, 0);

    drive(s, 1'b1);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    novalid(1'b1);
    @(negedge clk);
    chk("rst_mul", {out8(), bus8.o_valid, bus8.ex_busy}, 128'd0);
    cnt = 0;
    repeat (15) begin
      step();
      @(negedge clk);
      if (bus8.o_valid) cnt++;
    end
    chk("rst_mul_nores", cnt, 0);
    step();
    q8.push_back(mk(12, 0, 7, 1'b0, 9, 5'b00001));
    issue(add, 1'b1, 1'b0, nb, nv);

    for (int k = 0; k < 80; k++) begin
      bit sel;
      sel = (k >= 40);
      s = rnd();
      if (sel) q8.push_back(model(s, 8));
      else     q32.push_back(model(s, 32));
      issue(s, sel, 1'b1, nb, nv);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (4) step();
    chk("q32_drained", q32.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
